// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and helpers for the multi-port register bank.
//   DefDataW / DefNumRegs / DefNumRd / DefNumWr : default geometry
//   WR_PRIO_HIGH_IDX : write-port priority when two ports hit the same register
//   addr_width()     : address width for a given register count
package regbank_pkg;

   localparam int unsigned DefDataW   = 32;
   localparam int unsigned DefNumRegs = 16;
   localparam int unsigned DefNumRd   = 2;
   localparam int unsigned DefNumWr   = 1;

   // 1: the highest-indexed colliding write port wins (stored and forwarded value).
   // 0: the lowest-indexed port wins.
   localparam bit WR_PRIO_HIGH_IDX = 1'b1;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regbank_rd_port.sv
// regbank_rd_port: one registered read port of the register bank.
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   hold_i, clear_i  : shared pipeline freeze / flush (clear wins)
//   rd_addr_i        : read address, captured into addr_q (stage 1)
//   regs_i           : current register array contents
//   wr_addr_i/wr_data_i/wr_ok_i : same-cycle writes (wr_ok_i already excludes r0 if hardwired)
//   rd_data_o        : registered read data (stage 2)
module regbank_rd_port
   import regbank_pkg::*;
#(
   parameter int unsigned  DATA_W   = DefDataW,
   parameter int unsigned  NUM_REGS = DefNumRegs,
   parameter int unsigned  NUM_WR   = DefNumWr,
   parameter bit           ZERO_REG = 1'b1,
   localparam int unsigned AW       = addr_width(NUM_REGS)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     hold_i,
   input  logic                     clear_i,
   input  logic [AW-1:0]            rd_addr_i,
   input  logic [DATA_W-1:0]        regs_i [NUM_REGS],
   input  logic [NUM_WR*AW-1:0]     wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic [NUM_WR-1:0]        wr_ok_i,
   output logic [DATA_W-1:0]        rd_data_o
);

   logic [AW-1:0]     addr_q;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fwd_hit;

   // A write landing on this edge is not yet in regs_i, so bypass it.
   always_comb begin
      data_d  = regs_i[addr_q];
      fwd_hit = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_ok_i[k] && (wr_addr_i[k*AW +: AW] == addr_q) &&
             (WR_PRIO_HIGH_IDX || !fwd_hit)) begin
            data_d  = wr_data_i[k*DATA_W +: DATA_W];
            fwd_hit = 1'b1;
         end
      end
      if (ZERO_REG && (addr_q == '0)) begin
         data_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr_q <= '0;
         data_q <= '0;
      end else if (clear_i) begin
         addr_q <= '0;
         data_q <= '0;
      end else if (!hold_i) begin
         addr_q <= rd_addr_i;
         data_q <= data_d;
      end
   end

   assign rd_data_o = data_q;

endmodule

// File: rtl/regbank_mp.sv
// regbank_mp: multi-port register bank, NUM_REGS x DATA_W, NUM_RD registered read
// ports (2-cycle address-to-data latency), NUM_WR write ports with write-through
// forwarding, deterministic write priority and optional hardwired-zero r0.
//   clk, reset   : clock, asynchronous active-high reset
//   rd_addr      : read addresses, port i at [i*AW +: AW]
//   hold, clear  : freeze / flush both read pipeline stages (clear wins)
//   rd_data      : read data, port i at [i*DATA_W +: DATA_W]
//   wr_addr, wr_data, wr_en : write ports
//   wr_conflict  : two enabled ports hit the same writable register last cycle
module regbank_mp
   import regbank_pkg::*;
#(
   parameter int unsigned  DATA_W   = DefDataW,
   parameter int unsigned  NUM_REGS = DefNumRegs,
   parameter int unsigned  NUM_RD   = DefNumRd,
   parameter int unsigned  NUM_WR   = DefNumWr,
   parameter bit           ZERO_REG = 1'b1,
   localparam int unsigned AW       = addr_width(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   input  logic                     hold,
   input  logic                     clear,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_WR-1:0]        wr_en,
   output logic                     wr_conflict
);

   logic [NUM_WR-1:0] wr_ok;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wr_taken;
   logic              conflict_d, conflict_q;

   // Writes to r0 are dropped outright when it is hardwired to zero.
   always_comb begin
      wr_ok = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         wr_ok[k] = wr_en[k] && (!ZERO_REG || (wr_addr[k*AW +: AW] != '0));
      end
   end

   always_comb begin
      wr_taken = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         wr_taken  = 1'b0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_ok[k] && (wr_addr[k*AW +: AW] == AW'(r)) &&
                (WR_PRIO_HIGH_IDX || !wr_taken)) begin
               regs_d[r] = wr_data[k*DATA_W +: DATA_W];
               wr_taken  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int a = 0; a < NUM_WR; a++) begin
         for (int b = a + 1; b < NUM_WR; b++) begin
            if (wr_ok[a] && wr_ok[b] && (wr_addr[a*AW +: AW] == wr_addr[b*AW +: AW])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Writes proceed every edge, independent of hold/clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         conflict_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         conflict_q <= conflict_d;
      end
   end

   assign wr_conflict = conflict_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regbank_rd_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG)
      ) u_rd_port (
         .clk_i     (clk),
         .reset_i   (reset),
         .hold_i    (hold),
         .clear_i   (clear),
         .rd_addr_i (rd_addr[i*AW +: AW]),
         .regs_i    (regs_q),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_data),
         .wr_ok_i   (wr_ok),
         .rd_data_o (rd_data[i*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: two configurations of regbank_mp checked against a behavioural
// register-file model every cycle, plus hand-computed literal expectations.
//   dut_a: 16 regs, 2 read, 2 write ports, hardwired r0
//   dut_b: 32 regs, 3 read, 1 write port, r0 ordinary
module tb_regbank_mp;

   logic clk, reset, hold, clear;

   logic [7:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [7:0]  a_wr_addr;
   logic [63:0] a_wr_data;
   logic [1:0]  a_wr_en;
   logic        a_conf;

   logic [14:0] b_rd_addr;
   logic [95:0] b_rd_data;
   logic [4:0]  b_wr_addr;
   logic [31:0] b_wr_data;
   logic [0:0]  b_wr_en;
   logic        b_conf;

   int total = 0;
   int bad   = 0;

   regbank_mp #(
      .DATA_W   (32),
      .NUM_REGS (16),
      .NUM_RD   (2),
      .NUM_WR   (2),
      .ZERO_REG (1'b1)
   ) dut_a (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (a_rd_addr),
      .hold        (hold),
      .clear       (clear),
      .rd_data     (a_rd_data),
      .wr_addr     (a_wr_addr),
      .wr_data     (a_wr_data),
      .wr_en       (a_wr_en),
      .wr_conflict (a_conf)
   );

   regbank_mp #(
      .DATA_W   (32),
      .NUM_REGS (32),
      .NUM_RD   (3),
      .NUM_WR   (1),
      .ZERO_REG (1'b0)
   ) dut_b (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (b_rd_addr),
      .hold        (hold),
      .clear       (clear),
      .rd_data     (b_rd_data),
      .wr_addr     (b_wr_addr),
      .wr_data     (b_wr_data),
      .wr_en       (b_wr_en),
      .wr_conflict (b_conf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] ma_mem  [16];
   logic [3:0]  ma_addr [2];
   logic [31:0] ma_data [2];
   logic        ma_conf;
   logic [31:0] mb_mem  [32];
   logic [4:0]  mb_addr [3];
   logic [31:0] mb_data [3];

   // Value register r of A holds once this edge's writes land (later port overrides).
   function automatic logic [31:0] a_after(input int r);
      logic [31:0] v;
      if (r == 0) return 32'h0;
      v = ma_mem[r];
      for (int k = 0; k < 2; k++)
         if (a_wr_en[k] && int'(a_wr_addr[k*4 +: 4]) == r) v = a_wr_data[k*32 +: 32];
      return v;
   endfunction

   function automatic logic [31:0] b_after(input int r);
      logic [31:0] v;
      v = mb_mem[r];
      if (b_wr_en[0] && int'(b_wr_addr) == r) v = b_wr_data;
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 16; r++) ma_mem[r] <= 32'h0;
         for (int r = 0; r < 32; r++) mb_mem[r] <= 32'h0;
         for (int i = 0; i < 2; i++) begin ma_addr[i] <= 4'h0; ma_data[i] <= 32'h0; end
         for (int i = 0; i < 3; i++) begin mb_addr[i] <= 5'h0; mb_data[i] <= 32'h0; end
         ma_conf <= 1'b0;
      end else begin
         ma_conf <= (a_wr_en == 2'b11) && (a_wr_addr[3:0] == a_wr_addr[7:4]) &&
                    (a_wr_addr[3:0] != 4'h0);
         if (clear) begin
            for (int i = 0; i < 2; i++) begin ma_addr[i] <= 4'h0; ma_data[i] <= 32'h0; end
            for (int i = 0; i < 3; i++) begin mb_addr[i] <= 5'h0; mb_data[i] <= 32'h0; end
         end else if (!hold) begin
            for (int i = 0; i < 2; i++) begin
               ma_data[i] <= a_after(int'(ma_addr[i]));
               ma_addr[i] <= a_rd_addr[i*4 +: 4];
            end
            for (int i = 0; i < 3; i++) begin
               mb_data[i] <= b_after(int'(mb_addr[i]));
               mb_addr[i] <= b_rd_addr[i*5 +: 5];
            end
         end
         for (int r = 0; r < 16; r++) ma_mem[r] <= a_after(r);
         for (int r = 0; r < 32; r++) mb_mem[r] <= b_after(r);
      end
   end

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      chk("a_rd_data", 96'(a_rd_data), 96'({ma_data[1], ma_data[0]}));
      chk("a_conflict", 96'(a_conf), 96'(ma_conf));
      chk("b_rd_data", 96'(b_rd_data), {mb_data[2], mb_data[1], mb_data[0]});
      chk("b_conflict", 96'(b_conf), 96'h0);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      a_wr_en = 2'b00;
      b_wr_en = 1'b0;
   endtask

   task automatic a_wr(input int p, input logic [3:0] ad, input logic [31:0] d);
      a_wr_en[p]          = 1'b1;
      a_wr_addr[p*4 +: 4]  = ad;
      a_wr_data[p*32 +: 32] = d;
   endtask

   initial begin
      reset = 1'b1; hold = 1'b0; clear = 1'b0;
      a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_wr_en = '0;
      b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_en = '0;
      tick(); tick();
      chk("reset_a_rd", 96'(a_rd_data), 96'h0);
      chk("reset_conf", 96'(a_conf), 96'h0);
      reset = 1'b0;

      // Reset mid-operation
      a_wr(0, 4'd5, 32'hDEADBEEF);
      a_rd_addr[3:0] = 4'd5;
      tick(); idle();
      tick();
      chk("r5_read", 96'(a_rd_data[31:0]), 96'hDEADBEEF);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_a_rd", 96'(a_rd_data), 96'h0);
      chk("async_rst_conf", 96'(a_conf), 96'h0);
      chk("async_rst_b_rd", b_rd_data, 96'h0);
      tick(); reset = 1'b0;
      tick(); tick();
      chk("r5_after_reset", 96'(a_rd_data[31:0]), 96'h0);

      // Latency
      a_wr(0, 4'd3, 32'h12345678);
      tick(); idle();
      tick(); tick();
      a_rd_addr[3:0] = 4'd3;
      tick();
      chk("lat_not_yet", 96'(a_rd_data[31:0]), 96'h0);
      tick();
      chk("lat_ready", 96'(a_rd_data[31:0]), 96'h12345678);

      // Forwarding on read port 1
      a_rd_addr[7:4] = 4'd7;
      tick();
      a_wr(0, 4'd7, 32'hA5A5A5A5);
      tick();
      chk("fwd_same_edge", 96'(a_rd_data[63:32]), 96'hA5A5A5A5);
      idle();
      tick();
      chk("fwd_stored", 96'(a_rd_data[63:32]), 96'hA5A5A5A5);

      // Dual-write collision on r9, forwarded through port 0
      a_rd_addr[3:0] = 4'd9;
      tick();
      a_wr(0, 4'd9, 32'h1111);
      a_wr(1, 4'd9, 32'h2222);
      tick();
      chk("coll_fwd", 96'(a_rd_data[31:0]), 96'h2222);
      chk("coll_conf_set", 96'(a_conf), 96'h1);
      idle();
      tick();
      chk("coll_stored", 96'(a_rd_data[31:0]), 96'h2222);
      chk("coll_conf_clr", 96'(a_conf), 96'h0);

      // Collision on hardwired r0
      a_rd_addr[3:0] = 4'd0;
      tick();
      a_wr(0, 4'd0, 32'h3333);
      a_wr(1, 4'd0, 32'h4444);
      tick();
      chk("r0_coll_conf", 96'(a_conf), 96'h0);
      chk("r0_coll_rd", 96'(a_rd_data[31:0]), 96'h0);
      idle();
      tick();
      chk("r0_coll_conf2", 96'(a_conf), 96'h0);
      chk("r0_coll_rd2", 96'(a_rd_data[31:0]), 96'h0);

      // Ordinary r0 on the 3-read-port bank
      b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'h42;
      tick();
      b_wr_addr = 5'd4; b_wr_data = 32'h99;
      tick();
      idle();
      chk("b_r0_all_ports", b_rd_data, {32'h42, 32'h42, 32'h42});
      b_rd_addr = {5'd4, 5'd4, 5'd4};
      tick(); tick();
      chk("b_r4_all_ports", b_rd_data, {32'h99, 32'h99, 32'h99});

      // Hold for 3 cycles (with a write to the held address), then clear+hold
      a_wr(0, 4'd2, 32'h55);
      a_rd_addr[3:0] = 4'd2;
      tick(); idle();
      tick();
      chk("pre_hold", 96'(a_rd_data[31:0]), 96'h55);
      hold = 1'b1;
      a_rd_addr[3:0] = 4'd3;
      a_wr(0, 4'd2, 32'h66);
      tick(); idle();
      chk("hold_1", 96'(a_rd_data[31:0]), 96'h55);
      tick();
      chk("hold_2", 96'(a_rd_data[31:0]), 96'h55);
      tick();
      chk("hold_3", 96'(a_rd_data[31:0]), 96'h55);
      clear = 1'b1;
      tick();
      chk("clear_a", 96'(a_rd_data), 96'h0);
      chk("clear_b", b_rd_data, 96'h0);
      clear = 1'b0; hold = 1'b0;
      tick();
      chk("post_clear_a_addr0", 96'(a_rd_data[31:0]), 96'h0);
      chk("post_clear_b_addr0", b_rd_data, {32'h42, 32'h42, 32'h42});
      tick();
      chk("post_clear_a_r3", 96'(a_rd_data[31:0]), 96'h12345678);
      chk("post_clear_b_r4", b_rd_data, {32'h99, 32'h99, 32'h99});
      a_rd_addr[3:0] = 4'd2;
      tick(); tick();
      chk("held_write_landed", 96'(a_rd_data[31:0]), 96'h66);

      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised multi-port successor to the CPU register bank: NUM_REGS registers of DATA_W bits, NUM_RD read ports, NUM_WR write ports.
- Fully registered reads with 2-cycle address-to-data latency. Pipeline hold/clear is shared by all read ports.
- Write-through forwarding from every write port, deterministic write-port priority, and an optional hardwired-zero register 0.
- Sits between decode (read addresses, IF stage) and EX (read data); write ports are driven by WB and, on dual-issue builds, a second retire lane.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, register count; power of two, >= 2
- NUM_RD, 2, number of read ports, 1..4
- NUM_WR, 1, number of write ports, 1..2
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register
- AW (localparam), $clog2(NUM_REGS), address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
- hold  in  1  freeze both read pipeline stages
- clear  in  1  flush both read pipeline stages (insert bubble)
- rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_en  in  NUM_WR  per-port write enable
- wr_conflict  out  1  registered flag: two enabled write ports targeted the same writable register in the previous cycle

Behaviour:
- Reset (asynchronous, active-high): addr stage, rd_data, wr_conflict and every register cleared to 0 immediately, independent of clk. Deassertion is taken synchronously by the first following posedge.
- Stage 1 (posedge, !hold, !clear): addr_q[i] <= rd_addr[i].
- Stage 2 (same edge): rd_data[i] <= next_i.
  - next_i = forwarded wr_data if any enabled writable write port matches addr_q[i]; otherwise regs[addr_q[i]].
  - If ZERO_REG and addr_q[i]==0, next_i = 0.
- Latency: address presented at edge N appears on rd_data after edge N+2.
- Precedence: reset > clear > hold > normal.
  - clear: addr_q and rd_data go to 0 at the edge.
  - hold: addr_q and rd_data keep their values.
  - Simultaneous clear and hold: clear wins.
- Writes occur on every posedge regardless of hold/clear. Port k writes when wr_en[k] is set and (!ZERO_REG or wr_addr[k] != 0).
- Write priority: if both ports write the same register, the higher port index (port 1) wins, for both the stored value and the forwarded value.
- wr_conflict <= 1 at the edge after such a collision, 0 otherwise; it is only reported for writable targets.
- Forwarding covers only the same-cycle write vs addr_q. A write landing one cycle earlier is already in the array, so no extra path is needed.
- Hold with a concurrent write to the held address: rd_data keeps its stale value. This is intended; the hazard unit is responsible.
- Address/data slicing arithmetic is unsigned and exact; there is no wrap beyond NUM_REGS because AW addresses exactly that many registers.
- Simulation: registers initialised to 0 under the Icarus guard. Per-write $display trace in the existing format: time, register index, data.

Decomposition:
- Shared package/header regbank_pkg: AW computation macro, default widths, and the write-priority constant (WR_PRIO_HIGH_IDX).
- Sub-module regbank_rd_port: one instance per read port, generated with a for-generate loop. It contains addr_q, the forward-match mux across NUM_WR ports, zero-reg gating, and the output register; hold/clear/reset are shared.
- The register array and write/priority logic live in the top module.

Test Plan:
1. Reset mid-operation: write r5=0xDEADBEEF, then assert reset asynchronously between edges -> rd_data, wr_conflict and r5 read 0 immediately; a subsequent read of r5 returns 0.
2. Latency: write r3=0x12345678; two cycles later drive rd_addr[0]=3 at edge N -> rd_data[0]==0x12345678 after edge N+2, not after N+1.
3. Forwarding: addr_q[1]=7 while wr_en[0]=1, wr_addr=7, wr_data=0xA5A5A5A5 on the same edge -> rd_data[1]==0xA5A5A5A5 on that edge; the array holds the same value afterwards.
4. Dual-write collision (NUM_WR=2): both ports write r9, port0=0x1111, port1=0x2222 -> r9==0x2222, forwarded value is 0x2222, wr_conflict==1 for exactly one cycle. Repeat with target r0 and ZERO_REG=1 -> no write, wr_conflict stays 0, read returns 0.
5. Hold/clear: with rd_data[0]=0x55, hold=1 for 3 cycles -> output stays 0x55. Then assert clear and hold together -> rd_data and addr_q go to 0 at the next edge.
6. ZERO_REG=0, NUM_REGS=32, NUM_RD=3: write r0=0x42 -> all three ports reading addr 0 return 0x42 after 2 cycles.
